mem_port_arbiter: RTL and testbench

//  Shares the single multi-cycle memory port between the instruction-fetch requester (IF stages)
//  and the data requester (LWD/SWD MEM stages) of the multi-cycle TSC CPU.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_timeout_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state codes, requester IDs
// and the tie-break rule used when both requesters ask at once.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Round-robin hands a tie to whoever did not win last; fixed mode always favours data.
    function automatic req_id_t pick_requester(
        input logic    if_req,
        input logic    dm_req,
        input req_id_t last_grant,
        input logic    fixed_prio
    );
        if (if_req && dm_req) begin
            if (fixed_prio) return REQ_DM;
            return (last_grant == REQ_IF) ? REQ_DM : REQ_IF;
        end
        return dm_req ? REQ_DM : REQ_IF;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for one memory access: counts BUSY cycles and flags the last
// cycle the memory is allowed before the access is abandoned.
module mem_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a stuck enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single multi-cycle memory port between instruction fetch and
// data accesses; every output is a register so the memory sees clean strobes.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD     = 16,
    parameter int ADDR     = 16,
    parameter int TIMEOUT  = 8,
    parameter int PRIORITY = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [ADDR-1:0] if_addr,
    output logic            if_done,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [ADDR-1:0] dm_addr,
    input  logic [WORD-1:0] dm_wdata,
    output logic            dm_done,
    output logic [WORD-1:0] rdata,
    output logic            err,
    output logic            busy,
    output logic            mem_read,
    output logic            mem_write,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    input  logic            mem_ready
);

    arb_state_t      state, state_nxt;
    req_id_t         last_grant, last_grant_nxt;
    req_id_t         owner, owner_nxt;
    req_id_t         grant;
    logic            if_done_nxt, dm_done_nxt, err_nxt, busy_nxt;
    logic            mem_read_nxt, mem_write_nxt;
    logic [ADDR-1:0] mem_addr_nxt;
    logic [WORD-1:0] mem_wdata_nxt, rdata_nxt;
    logic            expired, ctr_clear, ctr_enable, finishing;

    assign finishing  = (state == BUSY) && (mem_ready || expired);
    assign ctr_enable = (state == BUSY);
    assign ctr_clear  = (state != BUSY) || finishing;

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .expired(expired)
    );

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        mem_read_nxt   = mem_read;
        mem_write_nxt  = mem_write;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        rdata_nxt      = rdata;
        busy_nxt       = busy;
        err_nxt        = 1'b0;
        if_done_nxt    = 1'b0;
        dm_done_nxt    = 1'b0;
        grant          = pick_requester(if_req, dm_req, last_grant, PRIORITY != 0);

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    if (grant == REQ_DM) begin
                        mem_addr_nxt  = dm_addr;
                        mem_wdata_nxt = dm_wdata;
                        mem_read_nxt  = !dm_we;
                        mem_write_nxt = dm_we;
                    end else begin
                        mem_addr_nxt  = if_addr;
                        mem_wdata_nxt = '0;
                        mem_read_nxt  = 1'b1;
                        mem_write_nxt = 1'b0;
                    end
                    busy_nxt  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            // A late mem_ready still counts as success even on the watchdog's last cycle.
            BUSY: begin
                if (finishing) begin
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    err_nxt       = !mem_ready;
                    if (mem_ready && !mem_write) rdata_nxt = mem_rdata;
                    if_done_nxt   = (owner == REQ_IF);
                    dm_done_nxt   = (owner == REQ_DM);
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
                busy_nxt      = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= REQ_IF;
            owner      <= REQ_IF;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            mem_read   <= mem_read_nxt;
            mem_write  <= mem_write_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            rdata      <= rdata_nxt;
            busy       <= busy_nxt;
            err        <= err_nxt;
            if_done    <= if_done_nxt;
            dm_done    <= dm_done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin and fixed-priority instances share
// one stimulus stream and are checked every cycle against a transaction model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset, if_req, dm_req, dm_we, mem_ready;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;

    logic        if_done0, dm_done0, err0, busy0, mem_read0, mem_write0;
    logic [15:0] rdata0, mem_addr0, mem_wdata0;
    logic        if_done1, dm_done1, err1, busy1, mem_read1, mem_write1;
    logic [15:0] rdata1, mem_addr1, mem_wdata1;

    int vectors = 0;
    int miscompares = 0;
    bit compare_on = 1'b0;
    bit logging = 1'b0;
    bit grant_log0[$];
    bit grant_log1[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD(16), .ADDR(16), .TIMEOUT(TIMEOUT), .PRIORITY(0)) dut_rr (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_done(if_done0),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done0),
        .rdata(rdata0), .err(err0), .busy(busy0), .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_port_arbiter #(.WORD(16), .ADDR(16), .TIMEOUT(TIMEOUT), .PRIORITY(1)) dut_fx (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_done(if_done1),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done1),
        .rdata(rdata1), .err(err1), .busy(busy1), .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Transaction view: an access is either waiting, in flight for "since" cycles, or reporting.
    typedef struct packed {
        bit          active;
        bit          finishing;
        bit          owner_dm;
        bit          last_dm;
        bit          we;
        int          since;
        bit          ifd, dmd, err, busy, rd, wr;
        logic [15:0] addr, wdata, rdata;
    } model_t;

    model_t mdl[2];

    function automatic model_t next_model(input model_t m, input bit fixed_prio);
        model_t n;
        bit pick_dm;
        n = m;
        if (reset) begin
            n = '0;
            return n;
        end
        n.ifd = 1'b0;
        n.dmd = 1'b0;
        n.err = 1'b0;
        if (m.finishing) begin
            n.finishing = 1'b0;
            n.busy = 1'b0;
        end else if (m.active) begin
            n.since = m.since + 1;
            if (mem_ready || n.since == TIMEOUT) begin
                n.active = 1'b0;
                n.finishing = 1'b1;
                n.rd = 1'b0;
                n.wr = 1'b0;
                n.err = !mem_ready;
                if (mem_ready && !m.we) n.rdata = mem_rdata;
                if (m.owner_dm) n.dmd = 1'b1;
                else n.ifd = 1'b1;
            end
        end else if (if_req || dm_req) begin
            pick_dm = dm_req && (!if_req || fixed_prio || !m.last_dm);
            n.active = 1'b1;
            n.since = 0;
            n.owner_dm = pick_dm;
            n.last_dm = pick_dm;
            n.we = pick_dm && dm_we;
            n.addr = pick_dm ? dm_addr : if_addr;
            n.wdata = pick_dm ? dm_wdata : 16'h0000;
            n.rd = !n.we;
            n.wr = n.we;
            n.busy = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        mdl[0] <= next_model(mdl[0], 1'b0);
        mdl[1] <= next_model(mdl[1], 1'b1);
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_on) begin
            check_output("cycle_rr",
                {10'd0, if_done0, dm_done0, err0, busy0, mem_read0, mem_write0, mem_addr0, mem_wdata0, rdata0},
                {10'd0, mdl[0].ifd, mdl[0].dmd, mdl[0].err, mdl[0].busy, mdl[0].rd, mdl[0].wr,
                 mdl[0].addr, mdl[0].wdata, mdl[0].rdata});
            check_output("cycle_fixed",
                {10'd0, if_done1, dm_done1, err1, busy1, mem_read1, mem_write1, mem_addr1, mem_wdata1, rdata1},
                {10'd0, mdl[1].ifd, mdl[1].dmd, mdl[1].err, mdl[1].busy, mdl[1].rd, mdl[1].wr,
                 mdl[1].addr, mdl[1].wdata, mdl[1].rdata});
        end
        if (logging) begin
            if (dm_done0) grant_log0.push_back(1'b1);
            if (if_done0) grant_log0.push_back(1'b0);
            if (dm_done1) grant_log1.push_back(1'b1);
            if (if_done1) grant_log1.push_back(1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-requester access; ready_at is the BUSY cycle that sees mem_ready (0 = never).
    task automatic apply_stimulus(
        input string       name,
        input bit          is_dm,
        input bit          we,
        input logic [15:0] addr,
        input logic [15:0] wdata,
        input logic [15:0] mdata,
        input int          ready_at,
        input bit          drop_early,
        input int          exp_strobe_cycles,
        input bit          exp_err,
        input logic [15:0] exp_rdata
    );
        int done_at;
        int strobes;
        done_at = (ready_at >= 1 && ready_at <= TIMEOUT) ? ready_at : TIMEOUT;
        strobes = 0;
        if_req = !is_dm;
        dm_req = is_dm;
        dm_we = is_dm && we;
        if_addr = is_dm ? 16'h0000 : addr;
        dm_addr = is_dm ? addr : 16'h0000;
        dm_wdata = wdata;
        mem_rdata = mdata;
        mem_ready = 1'b0;
        tick();
        if (drop_early) begin
            if_req = 1'b0;
            dm_req = 1'b0;
            if_addr = 16'hFFFF;
            dm_addr = 16'hFFFF;
        end
        for (int b = 1; b <= done_at; b++) begin
            mem_ready = (b == ready_at);
            if (mem_read0 || mem_write0) strobes++;
            check_output({name, "_addr_held"}, {48'd0, mem_addr0}, {48'd0, addr});
            tick();
        end
        check_output({name, "_done"}, {63'd0, is_dm ? dm_done0 : if_done0}, 64'd1);
        check_output({name, "_err"}, {63'd0, err0}, {63'd0, exp_err});
        check_output({name, "_rdata"}, {48'd0, rdata0}, {48'd0, exp_rdata});
        check_output({name, "_strobe_cycles"}, 64'(strobes), 64'(exp_strobe_cycles));
        if_req = 1'b0;
        dm_req = 1'b0;
        mem_ready = 1'b0;
        tick();
        check_output({name, "_done_pulse_width"}, {62'd0, if_done0, dm_done0}, 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit exp_rr[4];
        exp_rr = '{1'b1, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        if_req = 1'b1;
        dm_req = 1'b1;
        dm_we = 1'b0;
        if_addr = 16'h0000;
        dm_addr = 16'h0000;
        dm_wdata = 16'h0000;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;

        tick();
        compare_on = 1'b1;
        tick();
        check_output("reset_outputs",
            {6'd0, busy0, mem_read0, mem_write0, if_done0, dm_done0, err0, rdata0, mem_addr0, mem_wdata0},
            64'd0);

        $display("[TB] tie arbitration with both requests held");
        reset = 1'b0;
        mem_ready = 1'b1;
        logging = 1'b1;
        tick();
        check_output("first_grant_after_release", {62'd0, busy0, mem_read0}, 64'd3);
        repeat (11) tick();
        if_req = 1'b0;
        dm_req = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        logging = 1'b0;
        check_output("tie_rr_count", 64'(grant_log0.size()), 64'd4);
        check_output("tie_fixed_count", 64'(grant_log1.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log0.size(); i++)
            check_output($sformatf("tie_rr_grant%0d", i), {63'd0, grant_log0[i]}, {63'd0, exp_rr[i]});
        for (int i = 0; i < 4 && i < grant_log1.size(); i++)
            check_output($sformatf("tie_fixed_grant%0d", i), {63'd0, grant_log1[i]}, 64'd1);

        $display("[TB] single-requester accesses");
        apply_stimulus("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 3, 1'b0, 3, 1'b0, 16'hA5A5);
        apply_stimulus("store", 1'b1, 1'b1, 16'h0020, 16'h1234, 16'hDEAD, 1, 1'b0, 1, 1'b0, 16'hA5A5);
        apply_stimulus("timeout", 1'b0, 1'b0, 16'h0030, 16'h0000, 16'hBEEF, 0, 1'b0, 8, 1'b1, 16'hA5A5);
        apply_stimulus("ready_last", 1'b1, 1'b0, 16'h0040, 16'h5555, 16'h0F0F, 8, 1'b0, 8, 1'b0, 16'h0F0F);
        apply_stimulus("drop_mid", 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h3C3C, 3, 1'b1, 3, 1'b0, 16'h3C3C);

        $display("[TB] reset during an access");
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 16'h0050;
        mem_ready = 1'b0;
        tick();
        tick();
        check_output("busy_before_reset", {62'd0, busy0, mem_read0}, 64'd3);
        reset = 1'b1;
        tick();
        check_output("reset_in_busy",
            {58'd0, busy0, mem_read0, mem_write0, if_done0, dm_done0, err0}, 64'd0);
        reset = 1'b0;
        dm_req = 1'b0;
        tick();
        check_output("no_done_after_reset", {62'd0, if_done0, dm_done0}, 64'd0);
        tick();

        compare_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
